// File: rtl/clk_div_n.sv
// Integer clock divider with run enable, runtime divisor reload and a one-cycle period tick.
// Optional macro CLK_DIV_ODD_DUTY50_EN stretches the high phase by half a cycle for odd divisors.
module clk_div_n #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             clk_div,
    output logic             tick,
    output logic             dbg_state
);

    // Handshake: div_load is a one-cycle request strobe with no back-pressure. A request
    // with div_val < 2 is answered by div_err on the following cycle and changes nothing.
    // An accepted request is answered by exactly one div_ack in the cycle it takes effect
    // (next cycle from IDLE, first cycle of the next period from RUN); a newer accepted
    // request replaces one that has not been applied yet.

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
    localparam logic [WIDTH-1:0] RESET_N = WIDTH'(RESET_DIV);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] cur_n_q, cur_n_d;
    logic [WIDTH-1:0] pend_n_q, pend_n_d;
    logic             pend_v_q, pend_v_d;
    logic             div_q, div_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             load_ok;
    logic             wrap;

    assign load_ok = div_load && (div_val >= TWO);
    assign wrap    = (state_q == RUN) && (count_q == (cur_n_q - ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            cur_n_q  <= RESET_N;
            pend_n_q <= '0;
            pend_v_q <= 1'b0;
            div_q    <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            cur_n_q  <= cur_n_d;
            pend_n_q <= pend_n_d;
            pend_v_q <= pend_v_d;
            div_q    <= div_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        cur_n_d  = cur_n_q;
        pend_n_d = pend_n_q;
        pend_v_d = pend_v_q;
        ack_d    = 1'b0;
        err_d    = div_load && !load_ok;

        case (state_q)
            IDLE: begin
                count_d = '0;
                // A request left pending by a stop-at-wrap is applied first; a fresh load wins.
                if (pend_v_q) begin
                    cur_n_d  = pend_n_q;
                    pend_v_d = 1'b0;
                    ack_d    = 1'b1;
                end
                if (load_ok) begin
                    cur_n_d = div_val;
                    ack_d   = 1'b1;
                end
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (wrap) begin
                    count_d = '0;
                    if (pend_v_q) begin
                        cur_n_d  = pend_n_q;
                        pend_v_d = 1'b0;
                        ack_d    = 1'b1;
                    end
                    if (!en) begin
                        state_d = IDLE;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
                // A load landing on the wrap edge is parked; the old N closes this period.
                if (load_ok) begin
                    pend_n_d = div_val;
                    pend_v_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        div_d = (state_d == RUN) && (count_d < (cur_n_d >> 1));
    end

    assign tick      = (state_q == RUN) && (count_q == '0);
    assign div_ack   = ack_q;
    assign div_err   = err_q;
    assign dbg_state = state_q;

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic div_neg_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_neg_q <= 1'b0;
        end else begin
            div_neg_q <= div_q;
        end
    end

    // Select only changes at period boundaries where div_q is already high, so no glitch.
    assign clk_div = cur_n_q[0] ? (div_q | div_neg_q) : div_q;
`else
    assign clk_div = div_q;
`endif

endmodule

// File: doc/clk_div_n.md
CLK_DIV_N -- requirements
Module: clk_div_n

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, bit width of the divisor.
REQ-002 SHALL provide parameter RESET_DIV, default 3, divisor in effect after reset (legal range 2..2^WIDTH-1).
REQ-003 SHALL provide clk  input  1  clock.
REQ-004 SHALL provide rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide en  input  1  run enable.
REQ-006 SHALL provide div_val  input  WIDTH  requested divisor N.
REQ-007 SHALL provide div_load  input  1  request strobe; samples div_val.
REQ-008 SHALL provide div_ack  output  1  one-cycle pulse when a requested divisor takes effect.
REQ-009 SHALL provide div_err  output  1  one-cycle pulse when a request is rejected.
REQ-010 SHALL provide clk_div  output  1  divided clock, glitch-free.
REQ-011 SHALL provide tick  output  1  one-cycle clk-domain pulse at the start of each output period.

Function
REQ-012 SHALL implement states IDLE and RUN; in IDLE: count=0, clk_div=0, tick=0.
REQ-013 SHALL move IDLE->RUN on the first clk edge with en=1; the cycle after that edge has count=0, clk_div=1, tick=1.
REQ-014 SHALL, in RUN, increment count each clk edge and wrap N-1 -> 0; tick=1 exactly when count==0.
REQ-015 SHALL drive clk_div from a register (no combinational path from count); in RUN clk_div=1 iff count < floor(N/2).
REQ-016 SHALL, for even N, give exactly 50% duty (N/2 cycles high, N/2 low).
REQ-017 SHALL sample en only at wrap (count==N-1); en=0 there -> IDLE next edge; no period is truncated.
REQ-018 SHALL reject div_load with div_val<2: div_err pulses the next cycle, active divisor and pending request unchanged.
REQ-019 SHALL store an accepted div_load in a pending register; a newer accepted load before application overwrites it (one div_ack only).
REQ-020 SHALL, in RUN, apply a pending divisor at wrap so the next period uses the new N; div_ack pulses in that period's first cycle (count==0).
REQ-021 SHALL, in IDLE, apply an accepted load on the next edge; div_ack pulses the cycle after that edge.
REQ-022 SHALL, on simultaneous div_load and wrap, use the old N for the wrap and apply the new N at the following wrap.
REQ-023 SHALL handle N=2^WIDTH-1 without counter overflow.

Reset
REQ-024 SHALL, on rst_n=0, asynchronously force IDLE, count=0, active N=RESET_DIV, pending cleared, clk_div=0, tick=0, div_ack=0, div_err=0.
REQ-025 SHALL, on reset mid-period, abandon the period and drop any pending request; the first edge after release with en=1 follows REQ-013.

Configuration
REQ-026 SHALL honour macro CLK_DIV_ODD_DUTY50_EN.
REQ-027 SHALL, with CLK_DIV_ODD_DUTY50_EN defined, add a negedge-clk register capturing the posedge clk_div term and output their OR for odd N: high for floor(N/2)+0.5 cycles, 50% duty; even N unchanged; negedge register reset to 0.
REQ-028 SHALL, without CLK_DIV_ODD_DUTY50_EN, use posedge logic only; odd N gives floor(N/2) cycles high, ceil(N/2) low.

Verification
REQ-029 SHALL cover: reset, en=1, default N=3 -> clk_div 1,0,0 repeating; tick every 3rd cycle; without macro high 1 cycle, with macro high 1.5 cycles.
REQ-030 SHALL cover: RUN N=4, div_load div_val=6 at count=1 -> remaining period 4 cycles, then 6-cycle periods (3 high/3 low), one div_ack at first count==0 of N=6.
REQ-031 SHALL cover: div_load div_val=1, then div_val=0 -> div_err pulse each time, no div_ack, period stays unchanged.
REQ-032 SHALL cover: RUN N=5, en=0 at count=1 -> period completes (5 cycles), then IDLE, clk_div=0, no tick.
REQ-033 SHALL cover: N=8, rst_n low at count=2 -> all outputs 0 immediately; after release, en=1 -> N=3 (RESET_DIV) periods resume.
REQ-034 SHALL cover: WIDTH=8, N=255 -> 127 cycles high, 128 low (no macro), no wrap error; two loads 7 then 9 before wrap -> single div_ack, N=9 applied.
